// File: rtl/eq_tap_search_if.sv
// Handshake bundle between the eye-opening measurement stage, the tap search
// controller and the FFE driver it steers.
interface eq_tap_search_if #(
    parameter int TAP_WIDTH = 4
);
    logic                 start;
    real                  opening;
    logic                 opening_ready;
    logic [TAP_WIDTH-1:0] tap_code;
    real                  best_opening;
    logic                 busy;
    logic                 done;

    modport master (
        output start, opening, opening_ready,
        input  tap_code, best_opening, busy, done
    );

    modport slave (
        input  start, opening, opening_ready,
        output tap_code, best_opening, busy, done
    );
endinterface

// File: rtl/eq_tap_search.sv
// Transmit-equalizer tap search: sweeps every FFE tap code, averages the eye
// opening seen at each, then applies the code with the widest eye.
module eq_tap_search #(
    parameter int TAP_WIDTH      = 4,
    parameter int TAP_MAX        = 15,
    parameter int SETTLE_WINDOWS = 1,
    parameter int AVG_WINDOWS    = 2
) (
    input logic           clock,
    input logic           reset,
    eq_tap_search_if.slave bus
);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        UPDATE,
        APPLY
    } state_t;

    localparam logic [TAP_WIDTH-1:0] LAST_CODE   = TAP_WIDTH'(TAP_MAX);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_WINDOWS - 1);
    localparam logic [CNT_W-1:0]     AVG_LAST    = CNT_W'(AVG_WINDOWS - 1);
    // With no settle windows the tap change goes straight to measuring.
    localparam state_t AFTER_TAP = (SETTLE_WINDOWS == 0) ? MEASURE : SETTLE;

    state_t               state;
    logic [CNT_W-1:0]     settle_cnt;
    logic [CNT_W-1:0]     avg_cnt;
    logic [TAP_WIDTH-1:0] best_code;
    real                  acc;
    real                  avg_r;

    function automatic real window_avg(input real sum, input int n);
        return sum / $itor(n);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            avg_cnt          <= '0;
            best_code        <= '0;
            acc              <= 0.0;
            avg_r            <= 0.0;
            bus.tap_code     <= '0;
            bus.best_opening <= 0.0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.tap_code     <= '0;
                        settle_cnt       <= '0;
                        avg_cnt          <= '0;
                        acc              <= 0.0;
                        bus.best_opening <= 0.0;
                        best_code        <= '0;
                        bus.done         <= 1'b0;
                        bus.busy         <= 1'b1;
                        state            <= AFTER_TAP;
                    end
                end
                SETTLE: begin
                    // These windows straddle the tap change, so only count them.
                    if (bus.opening_ready) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            state      <= MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (bus.opening_ready) begin
                        acc     <= acc + bus.opening;
                        avg_cnt <= avg_cnt + 1'b1;
                        if (avg_cnt == AVG_LAST) begin
                            avg_r <= window_avg(acc + bus.opening, AVG_WINDOWS);
                            state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    // Strict compare keeps the lower code on ties.
                    if (bus.tap_code == '0 || avg_r > bus.best_opening) begin
                        bus.best_opening <= avg_r;
                        best_code        <= bus.tap_code;
                    end
                    acc     <= 0.0;
                    avg_cnt <= '0;
                    if (bus.tap_code < LAST_CODE) begin
                        bus.tap_code <= bus.tap_code + 1'b1;
                        state        <= AFTER_TAP;
                    end else begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    bus.tap_code <= best_code;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eq_tap_search.sv
// Directed bench for eq_tap_search: three instances cover the basic sweep,
// averaging with no settle windows, and tie handling.
module tb_eq_tap_search;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    eq_tap_search_if #(.TAP_WIDTH(4)) ifa ();
    eq_tap_search_if #(.TAP_WIDTH(4)) ifb ();
    eq_tap_search_if #(.TAP_WIDTH(4)) ifc ();

    eq_tap_search #(.TAP_WIDTH(4), .TAP_MAX(3), .SETTLE_WINDOWS(1), .AVG_WINDOWS(1))
        dut_a (.clock(clock), .reset(reset), .bus(ifa));
    eq_tap_search #(.TAP_WIDTH(4), .TAP_MAX(1), .SETTLE_WINDOWS(0), .AVG_WINDOWS(2))
        dut_b (.clock(clock), .reset(reset), .bus(ifb));
    eq_tap_search #(.TAP_WIDTH(4), .TAP_MAX(2), .SETTLE_WINDOWS(1), .AVG_WINDOWS(1))
        dut_c (.clock(clock), .reset(reset), .bus(ifc));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] tap_of(input int which);
        case (which)
            0:       return ifa.tap_code;
            1:       return ifb.tap_code;
            default: return ifc.tap_code;
        endcase
    endfunction

    function automatic real best_of(input int which);
        case (which)
            0:       return ifa.best_opening;
            1:       return ifb.best_opening;
            default: return ifc.best_opening;
        endcase
    endfunction

    function automatic logic busy_of(input int which);
        case (which)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    function automatic logic done_of(input int which);
        case (which)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    task automatic set_in(input int which, input logic st, input logic rdy, input real v);
        case (which)
            0:       begin ifa.start = st; ifa.opening_ready = rdy; ifa.opening = v; end
            1:       begin ifb.start = st; ifb.opening_ready = rdy; ifb.opening = v; end
            default: begin ifc.start = st; ifc.opening_ready = rdy; ifc.opening = v; end
        endcase
    endtask

    // One measurement window followed by one quiet cycle.
    task automatic pulse(input int which, input real v);
        @(negedge clock); set_in(which, 1'b0, 1'b1, v);
        @(negedge clock); set_in(which, 1'b0, 1'b0, 0.0);
        @(negedge clock);
    endtask

    task automatic start_sweep(input int which);
        @(negedge clock); set_in(which, 1'b1, 1'b0, 0.0);
        @(negedge clock); set_in(which, 1'b0, 1'b0, 0.0);
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic chk_tap(input int which, input string name, input logic [3:0] exp);
        total++;
        if (tap_of(which) !== exp) begin
            bad++;
            $display("FAIL %s: tap_code got %0d want %0d", name, tap_of(which), exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic chk_best(input int which, input string name, input real exp);
        real got;
        got = best_of(which);
        total++;
        if (got > exp + 1e-9 || got < exp - 1e-9) begin
            bad++;
            $display("FAIL %s: best_opening got %f want %f", name, got, exp);
        end
    endtask

    task automatic wait_done(input int which, input string name);
        int n;
        n = 0;
        while (done_of(which) !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        chk_bit({name, "_done"}, done_of(which), 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); @(negedge clock);
        chk_tap(0, "reset_tap", 4'd0);
        chk_best(0, "reset_best", 0.0);
        chk_bit("reset_busy", ifa.busy, 1'b0);
        chk_bit("reset_done", ifa.done, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_basic_sweep();
        // Pulse in IDLE, then start coinciding with a pulse: neither counts.
        pulse(0, 0.99);
        @(negedge clock); set_in(0, 1'b1, 1'b1, 0.99);
        @(negedge clock); set_in(0, 1'b0, 1'b0, 0.0);
        chk_bit("basic_busy", ifa.busy, 1'b1);
        chk_tap(0, "basic_tap0", 4'd0);
        pulse(0, 0.9); pulse(0, 0.30);
        chk_tap(0, "basic_tap1", 4'd1);
        pulse(0, 0.9); pulse(0, 0.55);
        chk_tap(0, "basic_tap2", 4'd2);
        pulse(0, 0.9); pulse(0, 0.42);
        chk_tap(0, "basic_tap3", 4'd3);
        pulse(0, 0.9); pulse(0, 0.20);
        wait_done(0, "basic");
        chk_tap(0, "basic_final_tap", 4'd1);
        chk_best(0, "basic_final_best", 0.55);
        chk_bit("basic_final_busy", ifa.busy, 1'b0);
    endtask

    task automatic test_averaging();
        start_sweep(1);
        pulse(1, 0.4); pulse(1, 0.6);
        chk_tap(1, "avg_tap1", 4'd1);
        pulse(1, 0.7); pulse(1, 0.1);
        wait_done(1, "avg");
        chk_tap(1, "avg_final_tap", 4'd0);
        chk_best(1, "avg_final_best", 0.5);
    endtask

    task automatic test_tie();
        start_sweep(2);
        for (int i = 0; i < 3; i++) begin
            pulse(2, 0.9); pulse(2, 0.45);
        end
        wait_done(2, "tie");
        chk_tap(2, "tie_tap", 4'd0);
        chk_best(2, "tie_best", 0.45);
    endtask

    task automatic test_reset_mid();
        start_sweep(0);
        pulse(0, 0.9); pulse(0, 0.3); pulse(0, 0.9);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        chk_tap(0, "rmid_tap", 4'd0);
        chk_bit("rmid_busy", ifa.busy, 1'b0);
        chk_bit("rmid_done", ifa.done, 1'b0);
        chk_best(0, "rmid_best", 0.0);
        reset = 1'b0;
        start_sweep(0);
        pulse(0, 0.9); pulse(0, 0.1);
        pulse(0, 0.9); pulse(0, 0.2);
        pulse(0, 0.9); pulse(0, 0.3);
        pulse(0, 0.9); pulse(0, 0.8);
        wait_done(0, "rmid");
        chk_tap(0, "rmid_final_tap", 4'd3);
        chk_best(0, "rmid_final_best", 0.8);
    endtask

    task automatic test_start_busy();
        start_sweep(0);
        pulse(0, 0.9); pulse(0, 0.6);
        start_sweep(0);
        chk_tap(0, "sbusy_tap", 4'd1);
        chk_bit("sbusy_busy", ifa.busy, 1'b1);
        pulse(0, 0.9); pulse(0, 0.5);
        chk_tap(0, "sbusy_tap2", 4'd2);
        pulse(0, 0.9); pulse(0, 0.7);
        pulse(0, 0.9); pulse(0, 0.65);
        wait_done(0, "sbusy");
        chk_tap(0, "sbusy_final_tap", 4'd2);
        chk_best(0, "sbusy_final_best", 0.7);
        start_sweep(0);
        chk_bit("restart_done", ifa.done, 1'b0);
        chk_tap(0, "restart_tap", 4'd0);
        chk_bit("restart_busy", ifa.busy, 1'b1);
    endtask

    task automatic test_dropped_pulse();
        do_reset();
        start_sweep(0);
        pulse(0, 0.9);
        // Measure pulse held two cycles: the second sample lands in UPDATE.
        @(negedge clock); set_in(0, 1'b0, 1'b1, 0.3);
        @(negedge clock);
        @(negedge clock); set_in(0, 1'b0, 1'b0, 0.0);
        @(negedge clock);
        chk_tap(0, "drop_tap1", 4'd1);
        pulse(0, 0.9);
        chk_tap(0, "drop_still1", 4'd1);
        pulse(0, 0.5);
        chk_tap(0, "drop_tap2", 4'd2);
        pulse(0, 0.9); pulse(0, 0.4);
        pulse(0, 0.9); pulse(0, 0.2);
        wait_done(0, "drop");
        chk_tap(0, "drop_final_tap", 4'd1);
        chk_best(0, "drop_final_best", 0.5);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        set_in(0, 1'b0, 1'b0, 0.0);
        set_in(1, 1'b0, 1'b0, 0.0);
        set_in(2, 1'b0, 1'b0, 0.0);
        test_reset();
        test_basic_sweep();
        test_averaging();
        test_tie();
        test_reset_mid();
        test_start_busy();
        test_dropped_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eq_tap_search.md
# eq_tap_search

Transmit-equalizer tap search controller. It sits directly downstream of the eye-opening measurement stage. It consumes that stage's per-window `opening` value and its `opening_ready` pulse, and drives the FFE de-emphasis tap code. The block sweeps every tap code and averages the eye opening measured at each code. It then applies the code that produced the widest eye and reports that opening.

## Interface
Parameters:
- `TAP_WIDTH`, 4: width of `tap_code`.
- `TAP_MAX`, 15: last code swept. Codes 0..`TAP_MAX` are tried; `TAP_MAX` ≤ 2^`TAP_WIDTH`−1.
- `SETTLE_WINDOWS`, 1: number of `opening_ready` pulses discarded after each tap change. Such a window straddles the change.
- `AVG_WINDOWS`, 2: number of `opening_ready` pulses averaged per code. Must be ≥ 1.

Ports:
- `clock`, input, 1: single clock; the same clock that produces `opening_ready`.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: single-cycle pulse that begins a sweep.
- `opening`, input, real: eye opening from the measurement stage; valid when `opening_ready`=1.
- `opening_ready`, input, 1: single-cycle pulse, one per measurement window.
- `tap_code`, output, `TAP_WIDTH`: tap code currently applied to the driver.
- `best_opening`, output, real: averaged opening of the best code found so far; the final value once `done`=1.
- `busy`, output, 1: high while a sweep is running.
- `done`, output, 1: high from sweep completion until the next `start` or `reset`.

## Operation
- All state and outputs are registered and update on the rising edge of `clock`.
- Reset values:
  - `tap_code`=0, `best_opening`=0.0, `busy`=0, `done`=0.
  - state=IDLE, all counters 0, accumulator 0.0, best code=0.
- IDLE:
  - On `start`: `tap_code`←0, clear the settle counter, average counter and accumulator, `best_opening`←0.0, best code←0, `done`←0, `busy`←1, go to SETTLE.
  - `opening_ready` is ignored in IDLE.
- SETTLE:
  - Each `opening_ready` pulse increments the settle counter.
  - When the counter reaches `SETTLE_WINDOWS`, clear it and go to MEASURE.
  - If `SETTLE_WINDOWS`=0, SETTLE is skipped entirely: the block goes straight to MEASURE.
- MEASURE:
  - Each `opening_ready` pulse adds `opening` to the accumulator and increments the average counter.
  - On the pulse that makes the counter reach `AVG_WINDOWS`, compute avg = (accumulator + `opening`) / `AVG_WINDOWS` in real arithmetic, then go to UPDATE.
- UPDATE (one cycle):
  - If avg > `best_opening` (strict), or this is code 0: `best_opening`←avg and best code←current code.
  - Ties keep the lower code.
  - Clear the accumulator and average counter.
  - If current code < `TAP_MAX`: `tap_code`←`tap_code`+1, go to SETTLE.
  - Otherwise go to APPLY.
- APPLY (one cycle): `tap_code`←best code, `busy`←0, `done`←1, go to IDLE.
- Total pulses consumed per sweep = (`TAP_MAX`+1)·(`SETTLE_WINDOWS`+`AVG_WINDOWS`).
- The code counter never wraps; it stops at `TAP_MAX`.

## Timing
- The `tap_code` increment is visible 2 cycles after the `opening_ready` edge that completes a code's average: one cycle to UPDATE, then registered.
- The final `tap_code` and `done`=1 are visible 2 cycles after the last averaged pulse plus the APPLY cycle, i.e. 3 edges after that pulse.
- An `opening_ready` pulse arriving during UPDATE or APPLY is dropped, not counted. The measurement stage never pulses on back-to-back cycles.
- `start` while `busy`=1 is ignored.
- `start` in the same cycle as `opening_ready` in IDLE: the sweep starts, and that pulse is not counted.
- `reset` mid-sweep: every output returns to its reset value on the next edge, and no partial result is applied.
- `start` and `reset` in the same cycle: `reset` wins.
- `done` stays high, with `tap_code` and `best_opening` held, until the next accepted `start`.

## Test plan
- Basic sweep. TAP_MAX=3, SETTLE=1, AVG=1; for codes 0..3, measured openings 0.30, 0.55, 0.42, 0.20 (settle windows carry 0.9) -> 8 pulses consumed; `done`=1, `tap_code`=1, `best_opening`=0.55, `busy`=0.
- Averaging. TAP_MAX=1, SETTLE=0, AVG=2; openings 0.4, 0.6 (code 0) then 0.7, 0.1 (code 1) -> averages 0.5 and 0.4; final `tap_code`=0, `best_opening`=0.5.
- Tie. TAP_MAX=2, all averages 0.45 -> `tap_code`=0, `best_opening`=0.45.
- Reset mid-sweep. Assert `reset` after 3 pulses -> next edge `tap_code`=0, `busy`=0, `done`=0, `best_opening`=0.0. A following `start` runs a full sweep from code 0.
- Start ignored while busy. Pulse `start` mid-sweep -> sweep continues with unchanged code and pulse counts. A `start` after `done` clears `done`, sets `tap_code`=0, and restarts the sweep.
- Dropped pulse. Deliver `opening_ready` in the UPDATE cycle -> it is not counted, and the next code still requires `SETTLE_WINDOWS`+`AVG_WINDOWS` further pulses.
